// File: rtl/ps2_event_decoder.sv
// PS/2 scan-code stream to key-event decoder: E0/F0/E1 prefix handling,
// optional typematic-repeat filter and a valid/ready event FIFO.
module ps2_event_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_REPEAT  = 1,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PAUSE_LEN      = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW   = $clog2(PAUSE_LEN + 1);
  localparam bit FILT = (FILTER_REPEAT != 0);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   skip, skip_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            emit, em_ext, em_brk;
  logic [7:0]      em_code;
  logic            lm_valid;
  logic [8:0]      lm;
  logic            suppress, push;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            pop, full, wr_en, drop;

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    emit      = 1'b0;
    em_code   = rx_data;
    em_ext    = 1'b0;
    em_brk    = 1'b0;
    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          unique case (rx_data)
            8'hE0: state_nxt = S_EXT;
            8'hF0: state_nxt = S_BRK;
            8'hE1: begin
              state_nxt = S_PAUSE;
              skip_nxt  = SW'(PAUSE_LEN);
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: emit = 1'b1;
          endcase
        end
        S_EXT: begin
          if (rx_data == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else if (rx_data != 8'hE0) begin
            emit      = 1'b1;
            em_ext    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          state_nxt = S_IDLE;
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            emit   = 1'b1;
            em_ext = (state == S_EXT_BRK);
            em_brk = 1'b1;
          end
        end
        S_PAUSE: begin
          skip_nxt = skip - SW'(1);
          if (skip == SW'(1)) begin
            emit      = 1'b1;
            em_code   = 8'hE1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = S_IDLE;
    end
  end

  // Repeat filter sits before the FIFO, so a dropped (overflowed) make still counts as "last make".
  assign suppress = FILT && emit && !em_brk && lm_valid && (lm == {em_ext, em_code});
  assign push     = emit && !suppress;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      skip     <= '0;
      tmo_cnt  <= '0;
      lm_valid <= 1'b0;
      lm       <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
      if (rx_valid || state == S_IDLE || tmo_cnt == TW'(TIMEOUT_CYCLES - 1))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);
      if (FILT && emit) begin
        if (em_brk) begin
          lm_valid <= 1'b0;
        end else if (!suppress) begin
          lm       <= {em_ext, em_code};
          lm_valid <= 1'b1;
        end
      end
    end
  end

  assign pop   = (count != '0) && ev_ready;
  assign full  = (count == CW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {em_code, em_ext, em_brk};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign ev_valid   = (count != '0);
  assign ev_code    = mem[rd_ptr][9:2];
  assign ev_ext     = mem[rd_ptr][1];
  assign ev_break   = mem[rd_ptr][0];
  assign fifo_count = count;

endmodule

// File: doc/ps2_event_decoder.md
Name: ps2_event_decoder

Overview:
Turns the raw PS/2 byte stream from the keyboard receiver into complete key events. It handles E0 extended prefixes, F0 break prefixes and the E1 Pause sequence, and can suppress typematic repeats. Events are buffered in a parametrised FIFO and read out over a valid/ready interface by the UART formatter or game logic. This replaces the 16-bit keycode compare-and-latch scheme with a generalised, buffered decoder.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; must be a power of two, 2..64
FILTER_REPEAT, 1, 1 = drop a make event that is identical to the last make with no break in between; 0 = pass all makes
TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one multi-byte sequence before the decoder aborts it
PAUSE_LEN, 7, bytes that follow E1 in the Pause sequence

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_data  in  8  byte from the PS/2 receiver
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer accepts the head event when ev_valid and ev_ready are both high
ev_code  out  8  head event scan code
ev_ext  out  1  head event had the E0 prefix
ev_break  out  1  head event is a release
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (async, active-high) sets:
  - outputs: ev_valid=0, fifo_count=0, overflow=0, ev_code/ev_ext/ev_break=0
  - state=IDLE, last_make_valid=0, timeout counter=0
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions occur only on cycles with rx_valid=1:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE (skip counter=PAUSE_LEN).
  - IDLE: 00, AA, EE, FA, FE, FF are discarded and the state stays IDLE.
  - IDLE: any other byte emits {code, ext=0, break=0}.
  - EXT: F0 -> EXT_BRK; E0 is ignored (stay in EXT); any other byte emits {code, 1, 0} -> IDLE.
  - BRK: any byte except E0/F0 emits {code, 0, 1} -> IDLE; E0 or F0 -> IDLE with no event.
  - EXT_BRK: any byte except E0/F0 emits {code, 1, 1} -> IDLE; E0 or F0 -> IDLE with no event.
  - PAUSE: each byte decrements the skip counter. On the byte that reaches 0, emit {E1, 0, 0} once and go to IDLE.
- Timeout:
  - The counter clears on every rx_valid and counts while the state is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the state goes to IDLE with no event.
  - An rx_valid in that same cycle wins: the byte is processed normally.
- Repeat filter (FILTER_REPEAT=1):
  - A make equal to last_make ({ext,code}) while last_make_valid=1 is suppressed.
  - Any make that is not suppressed loads last_make and sets last_make_valid.
  - Any break clears last_make_valid. Breaks are never suppressed.
  - With FILTER_REPEAT=0 the filter logic is inert.
- Latency: for a byte with rx_valid in cycle k that completes an event, the event is written at the clk edge ending cycle k. If the FIFO was empty, ev_valid=1 in cycle k+1.
- FIFO:
  - 10-bit entries, first-in first-out.
  - ev_code/ev_ext/ev_break always show the head entry and are stable while ev_valid=1 and ev_ready=0.
  - Pop when ev_valid&&ev_ready. Pop while empty is ignored.
  - Push and pop in the same cycle: fifo_count is unchanged. This applies when full too: the push is accepted because a slot frees.
  - Push while full without a pop: the event is dropped and overflow goes to 1 on the next edge.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- overflow: ovf_clr=1 clears it. A new drop in the same cycle as ovf_clr wins, so overflow stays 1.
- Back-to-back rx_valid in consecutive cycles must be handled without loss.

Test Plan:
- Bytes 1C, F0 1C with ev_ready=1 -> events {1C,0,0} then {1C,0,1}; ev_valid rises 1 cycle after each final byte.
- Bytes E0 75, E0 F0 75 -> {75,1,0} then {75,1,1}; fifo_count peaks at 1 while ev_ready=1.
- FILTER_REPEAT=1, bytes 1C 1C 1C F0 1C 1C -> exactly 3 events: make, break, make. With FILTER_REPEAT=0 -> 5 events.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> a single event {E1,0,0}; the next byte 29 -> {29,0,0}.
- ev_ready=0, FIFO_DEPTH=8, 10 make events of distinct codes -> fifo_count=8, overflow=1, first 8 codes drain in order. Then ovf_clr -> overflow=0.
- Byte E0 then idle for TIMEOUT_CYCLES -> no event, state IDLE; next byte 1C -> {1C,0,0}. Also assert rst during EXT -> all outputs 0 immediately.
